// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, frame size,
// common keyboard command bytes and the frame builder.
package ps2_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;

  localparam int PS2_FRAME_BITS = 10;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // {stop, odd parity, d7..d0}; shifted out LSB first
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(
    input logic [7:0] b
  );
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line synchroniser and clock falling-edge detector.
// Ports: clk, reset_L, ps2_clk_i/ps2_data_i raw lines,
// sync_clk_o/sync_data_o synced levels, fe_o registered fall pulse.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_L,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic sync_clk_o,
  output logic sync_data_o,
  output logic fe_o
);

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] data_q;
  logic                   prev_q;
  logic                   fe_q;

  // idle bus is high, so the chains reset to 1
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      clk_q  <= '1;
      data_q <= '1;
      prev_q <= 1'b1;
      fe_q   <= 1'b0;
    end else begin
      clk_q  <= {clk_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_q <= {data_q[SYNC_STAGES-2:0], ps2_data_i};
      prev_q <= clk_q[SYNC_STAGES-1];
      fe_q   <= prev_q & ~clk_q[SYNC_STAGES-1];
    end
  end

  assign sync_clk_o  = clk_q[SYNC_STAGES-1];
  assign sync_data_o = data_q[SYNC_STAGES-1];
  assign fe_o        = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter with open-drain line control.
// Ports: clk, reset_L, tx_data/tx_valid/tx_ready handshake,
// tx_done/tx_error pulses, busy, raw ps2 inputs, ps2 *_oe pull-downs.
// Optional watchdog: define PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  logic sync_clk;
  logic sync_data;
  logic fe;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset_L    (reset_L),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_data_i (ps2_data_in),
    .sync_clk_o (sync_clk),
    .sync_data_o(sync_data),
    .fe_o       (fe)
  );

  logic [2:0]                state_q, state_d;
  logic [IW-1:0]             icnt_q, icnt_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]                bit_q, bit_d;
  logic                      clk_oe_q, clk_oe_d;
  logic                      data_oe_q, data_oe_d;
  logic                      ok_q, ok_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    icnt_d    = icnt_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ok_d      = ok_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d   = ps2_frame(tx_data);
          bit_d     = 4'd0;
          icnt_d    = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        // the RTS cycle completes the clock-low window
        if (icnt_q == IW'(INHIBIT_CYCLES - 2)) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          icnt_d = icnt_q + 1'b1;
        end
      end
      S_RTS: begin
        clk_oe_d = 1'b0;
        state_d  = S_DATA;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        wd_d     = '0;
`endif
      end
      S_DATA: begin
        if (fe) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[PS2_FRAME_BITS-1:1]};
          if (bit_q == 4'd9) begin
            state_d = S_ACK;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fe) begin
          ok_d    = ~sync_data;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sync_clk && sync_data) begin
          done_d  = ok_q;
          err_d   = ~ok_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
    if (state_q == S_DATA || state_q == S_ACK) begin
      if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        err_d     = 1'b1;
        state_d   = S_IDLE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= S_IDLE;
      icnt_q    <= '0;
      shift_q   <= '0;
      bit_q     <= 4'd0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ok_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      icnt_q    <= icnt_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ok_q      <= ok_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tx_done     = done_q;
  assign tx_error    = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
